commit_trace: RTL and testbench

COMMIT_TRACE -- requirements
Module: commit_trace

---
 rtl/commit_trace_pkg.sv | 39 +++
 rtl/commit_trace_if.sv | 28 ++
 rtl/trace_fifo.sv | 55 +++++
 rtl/commit_trace.sv | 118 +++++++++++
 tb/tb_commit_trace.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: event kinds, the queued trace entry
// and the drain FSM states, plus the event qualification rule.
package commit_trace_pkg;

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_CSR   = 2'd1,
    KIND_STORE = 2'd2,
    KIND_RSVD  = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A store with no byte enables writes nothing, so it is not worth tracing.
  function automatic logic is_qualified(input logic vld, input kind_e kind,
                                        input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    case (kind)
      KIND_REG, KIND_CSR: ok = 1'b1;
      KIND_STORE:         ok = |strb;
      default:            ok = 1'b0;
    endcase
    return vld && ok;
  endfunction

endpackage

// File: rtl/commit_trace_if.sv
// Retire-event input and trace-entry output stream of the commit trace buffer.
// master = event producer / trace consumer, slave = the buffer itself.
interface commit_trace_if;
  logic        ev_valid;
  logic [1:0]  ev_kind;
  logic [31:0] ev_pc;
  logic [31:0] ev_addr;
  logic [31:0] ev_data;
  logic [3:0]  ev_strb;

  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_strb;

  modport master (
    output ev_valid, ev_kind, ev_pc, ev_addr, ev_data, ev_strb, out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data, out_strb
  );

  modport slave (
    input  ev_valid, ev_kind, ev_pc, ev_addr, ev_data, ev_strb, out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data, out_strb
  );
endinterface

// File: rtl/trace_fifo.sv
// Power-of-two FIFO of trace entries; head is visible the cycle after the first push.
// Caller guarantees no push when full without a pop, and no pop when empty.
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  entry_t                   i_push_dat,
  input  logic                     i_pop,
  output entry_t                   o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_level;

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = (r_level == FULL_LVL);
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;

endmodule

// File: rtl/commit_trace.sv
// Buffers qualified retire events for a trace consumer until a tohost store is seen,
// then drains and signals done; full FIFO drops events and counts them (saturating).
module commit_trace
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OVF_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  commit_trace_if.slave            bus,
  input  logic [31:0]              host_addr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [OVF_W-1:0]         overflow,
  output logic                     done,
  output logic [31:0]              done_data
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_e             r_state;
  logic [OVF_W-1:0]   r_ovf;
  logic               r_done;
  logic [31:0]        r_done_data;

  entry_t             w_ev;
  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic [LW-1:0]      w_level;
  logic               w_run;
  logic               w_qual;
  logic               w_out_vld;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_tohost;
  logic               w_last_pop;
  logic               w_unused_host;

  assign w_ev = '{
    kind: kind_e'(bus.ev_kind),
    pc:   bus.ev_pc,
    addr: bus.ev_addr,
    data: bus.ev_data,
    strb: bus.ev_strb
  };

  assign w_run     = (r_state == ST_RUN);
  assign w_qual    = is_qualified(bus.ev_valid, w_ev.kind, bus.ev_strb);
  assign w_out_vld = !w_empty && (r_state != ST_DONE);
  assign w_pop     = w_out_vld && bus.out_ready;
  assign w_push    = w_run && w_qual && (!w_full || w_pop);
  assign w_drop    = w_run && w_qual && w_full && !w_pop;
  // tohost matches on the word, so any byte lane of that word counts.
  assign w_tohost  = w_run && w_qual && (w_ev.kind == KIND_STORE) &&
                     (bus.ev_addr[31:2] == host_addr[31:2]);
  assign w_last_pop = w_empty || ((w_level == LW'(1)) && w_pop);
  assign w_unused_host = ^host_addr[1:0];

  trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (w_ev),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (w_level)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_ovf       <= '0;
      r_done      <= 1'b0;
      r_done_data <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_tohost) begin
            r_done_data <= bus.ev_data;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_pop) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_DONE;
        end
      endcase
      if (w_drop && (r_ovf != '1)) begin
        r_ovf <= r_ovf + 1'b1;
      end
    end
  end

  // Fields read as zero whenever nothing is offered.
  assign bus.out_valid = w_out_vld;
  assign bus.out_kind  = w_out_vld ? w_head.kind : 2'b00;
  assign bus.out_pc    = w_out_vld ? w_head.pc   : 32'h0;
  assign bus.out_addr  = w_out_vld ? w_head.addr : 32'h0;
  assign bus.out_data  = w_out_vld ? w_head.data : 32'h0;
  assign bus.out_strb  = w_out_vld ? w_head.strb : 4'h0;

  assign level     = w_level;
  assign overflow  = r_ovf;
  assign done      = r_done;
  assign done_data = r_done_data;

endmodule

// File: tb/tb_commit_trace.sv
// Directed bench for commit_trace: a queue-based model checked every cycle,
// plus literal pins for the headline scenarios.
module tb_commit_trace;
  import commit_trace_pkg::*;

  localparam int DEPTH   = 16;
  localparam int OVF_W   = 3;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  localparam int L_LEVEL = 1;
  localparam int L_OVF   = 2;
  localparam int L_DD    = 3;
  localparam int L_PC    = 4;
  localparam int L_DONE  = 5;
  localparam int L_VLD   = 6;

  logic        clock;
  logic        reset;
  logic [31:0] host_addr;
  logic [4:0]  level;
  logic [2:0]  overflow;
  logic        done;
  logic [31:0] done_data;

  commit_trace_if bus();

  commit_trace #(
    .DEPTH(DEPTH),
    .OVF_W(OVF_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .host_addr (host_addr),
    .level     (level),
    .overflow  (overflow),
    .done      (done),
    .done_data (done_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state
  entry_t      mq[$];
  int          m_ovf;
  bit          m_drain;
  bit          m_done;
  logic [31:0] m_dd;

  // Literal pin request, written only by the stimulus process
  bit          chk_en;
  int          lit_sel;
  logic [31:0] lit_exp;
  string       lit_name;

  // Counters, written only by the compare process
  int errors;
  int checks;
  bit exp_vld;

  task automatic model_update();
    entry_t e;
    bit     qual;
    if (reset) begin
      mq.delete();
      m_ovf   = 0;
      m_drain = 0;
      m_done  = 0;
      m_dd    = 32'h0;
      return;
    end
    qual = bus.ev_valid && ((bus.ev_kind == 2'd0) || (bus.ev_kind == 2'd1) ||
                            (bus.ev_kind == 2'd2 && bus.ev_strb != 4'h0));
    if (!m_done && mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
    if (!m_drain && !m_done) begin
      if (qual) begin
        e.kind = kind_e'(bus.ev_kind);
        e.pc   = bus.ev_pc;
        e.addr = bus.ev_addr;
        e.data = bus.ev_data;
        e.strb = bus.ev_strb;
        if (mq.size() < DEPTH) mq.push_back(e);
        else if (m_ovf < OVF_MAX) m_ovf = m_ovf + 1;
        if (bus.ev_kind == 2'd2 && bus.ev_addr[31:2] == host_addr[31:2]) begin
          m_dd    = bus.ev_data;
          m_drain = 1;
        end
      end
    end else if (m_drain && mq.size() == 0) begin
      m_drain = 0;
      m_done  = 1;
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      exp_vld = !m_done && (mq.size() > 0);
      cmp("out_valid", 32'(bus.out_valid), 32'(exp_vld));
      if (exp_vld) begin
        cmp("out_kind", 32'(bus.out_kind), 32'(mq[0].kind));
        cmp("out_pc",   bus.out_pc,   mq[0].pc);
        cmp("out_addr", bus.out_addr, mq[0].addr);
        cmp("out_data", bus.out_data, mq[0].data);
        cmp("out_strb", 32'(bus.out_strb), 32'(mq[0].strb));
      end
      cmp("level",     32'(level),    32'(mq.size()));
      cmp("overflow",  32'(overflow), 32'(m_ovf));
      cmp("done",      32'(done),     32'(m_done));
      cmp("done_data", done_data,     m_dd);
      case (lit_sel)
        L_LEVEL: cmp(lit_name, 32'(level),         lit_exp);
        L_OVF:   cmp(lit_name, 32'(overflow),      lit_exp);
        L_DD:    cmp(lit_name, done_data,          lit_exp);
        L_PC:    cmp(lit_name, bus.out_pc,         lit_exp);
        L_DONE:  cmp(lit_name, 32'(done),          lit_exp);
        L_VLD:   cmp(lit_name, 32'(bus.out_valid), lit_exp);
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    model_update();
    lit_sel = 0;
    #1;
  endtask

  task automatic pin(input int sel, input logic [31:0] exp, input string nm);
    lit_sel  = sel;
    lit_exp  = exp;
    lit_name = nm;
  endtask

  task automatic set_ev(input bit v, input logic [1:0] k, input logic [31:0] pc,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    bus.ev_valid = v;
    bus.ev_kind  = k;
    bus.ev_pc    = pc;
    bus.ev_addr  = addr;
    bus.ev_data  = data;
    bus.ev_strb  = strb;
  endtask

  task automatic idle();
    set_ev(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    chk_en    = 0;
    lit_sel   = 0;
    lit_exp   = 32'h0;
    lit_name  = "";
    m_ovf     = 0;
    m_drain   = 0;
    m_done    = 0;
    m_dd      = 32'h0;
    reset     = 1'b1;
    host_addr = 32'h8000_1000;
    bus.out_ready = 1'b0;
    idle();

    // Reset state; out_ready and events are ignored during reset
    tick();
    chk_en = 1;
    pin(L_LEVEL, 32'd0, "reset_level");
    bus.out_ready = 1'b1;
    set_ev(1'b1, 2'd0, 32'h44, 32'h1, 32'h2, 4'h0);
    tick();
    pin(L_VLD, 32'd0, "reset_out_valid");

    // Single REG event, latency 1, popped immediately
    reset = 1'b0;
    set_ev(1'b1, 2'd0, 32'h8000_0000, 32'd5, 32'h1234, 4'h0);
    tick();
    pin(L_PC, 32'h8000_0000, "first_pc");
    idle();
    tick();
    pin(L_LEVEL, 32'd0, "first_level_back");

    // Zero-strobe stores and reserved kind are discarded
    bus.out_ready = 1'b0;
    set_ev(1'b1, 2'd2, 32'h10, 32'h200, 32'h77, 4'h0);
    tick();
    set_ev(1'b1, 2'd3, 32'h14, 32'h204, 32'h78, 4'hF);
    tick();
    set_ev(1'b1, 2'd2, 32'h18, 32'h8000_1000, 32'h79, 4'h0);
    tick();
    pin(L_OVF, 32'd0, "discard_ovf");
    idle();
    tick();
    pin(L_LEVEL, 32'd0, "discard_level");

    // 20 events into a 16-deep FIFO with no consumer
    for (int i = 1; i <= 20; i++) begin
      set_ev(1'b1, 2'd0, 32'h1000 + 32'(4 * i), 32'(i % 32), 32'(i), 4'h0);
      tick();
    end
    idle();
    pin(L_LEVEL, 32'd16, "fill_level");
    tick();
    pin(L_OVF, 32'd4, "fill_ovf");

    // Full FIFO with simultaneous push and pop
    set_ev(1'b1, 2'd1, 32'h2000, 32'h300, 32'h0000_00AA, 4'h0);
    bus.out_ready = 1'b1;
    tick();
    idle();
    bus.out_ready = 1'b0;
    pin(L_LEVEL, 32'd16, "pushpop_level");
    tick();
    pin(L_OVF, 32'd4, "pushpop_ovf");

    // Overflow counter saturates
    for (int i = 0; i < 5; i++) begin
      set_ev(1'b1, 2'd1, 32'h3000, 32'h301, 32'(i), 4'h0);
      tick();
    end
    idle();
    pin(L_OVF, 32'd7, "ovf_saturated");

    // Drain everything
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    pin(L_LEVEL, 32'd0, "drained_level");

    // Mixed traffic with intermittent backpressure
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = (i % 3) != 0;
      if (i % 2 == 0)
        set_ev(1'b1, 2'(i % 3), 32'h4000 + 32'(i), 32'h40 + 32'(i),
               32'hC0DE_0000 + 32'(i), 4'(1 << (i % 4)));
      else
        idle();
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Reset mid-operation with entries queued and an event presented
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ev(1'b1, 2'd0, 32'h5000 + 32'(i), 32'(i), 32'h500 + 32'(i), 4'h0);
      tick();
    end
    pin(L_LEVEL, 32'd5, "pre_reset_level");
    reset = 1'b1;
    bus.out_ready = 1'b1;
    set_ev(1'b1, 2'd1, 32'h5100, 32'h7, 32'h99, 4'h0);
    tick();
    pin(L_LEVEL, 32'd0, "midreset_level");
    reset = 1'b0;
    bus.out_ready = 1'b0;
    set_ev(1'b1, 2'd0, 32'h5200, 32'h3, 32'h42, 4'h0);
    tick();
    pin(L_LEVEL, 32'd1, "after_reset_push");
    idle();
    bus.out_ready = 1'b1;
    tick();

    // tohost store with three entries queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ev(1'b1, 2'd0, 32'h6000 + 32'(4 * i), 32'(i + 1), 32'h600 + 32'(i), 4'h0);
      tick();
    end
    set_ev(1'b1, 2'd2, 32'h600C, 32'h8000_1002, 32'h1, 4'b0001);
    tick();
    pin(L_DD, 32'h1, "tohost_data");
    set_ev(1'b1, 2'd0, 32'h6010, 32'h9, 32'h77, 4'h0);
    tick();
    pin(L_LEVEL, 32'd4, "drain_ignores_events");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pin(L_DONE, 32'd0, "done_before_last_pop");
    tick();
    pin(L_DONE, 32'd1, "done_after_last_pop");
    tick();
    pin(L_VLD, 32'd0, "done_out_valid");
    tick();

    // tohost store dropped because the FIFO is full
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ev(1'b1, 2'd1, 32'h7000 + 32'(i), 32'h100 + 32'(i), 32'(i), 4'h0);
      tick();
    end
    set_ev(1'b1, 2'd2, 32'h7100, 32'h8000_1000, 32'h55, 4'hC);
    tick();
    pin(L_DD, 32'h55, "dropped_tohost_data");
    idle();
    tick();
    pin(L_OVF, 32'd1, "dropped_tohost_ovf");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    pin(L_DONE, 32'd1, "dropped_tohost_done");
    tick();

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
